// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
//
// Programmable clock-enable / divided-clock controller. An internal
// WIDTH-bit up-counter runs through IDLE -> RUN -> DRAIN -> IDLE phases.
// Each period lasts div_q cycles. The last cycle of a period (the wrap
// cycle) raises a one-cycle `tick`. A registered `div_clk` is high for the
// first ceil(div_q/2) counts of every period. New ratios arrive over a
// valid/ready port into a one-entry pending buffer. They are applied only
// at a period boundary, or while idle, so a period is never truncated.
//
// Handshake: a transfer happens on a rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready is high exactly when the pending
// buffer is empty. A transferred ratio of 0 is dropped, and cfg_err
// pulses for one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides every other input)
//   enable     run request (level)
//   cfg_valid  ratio offered
//   cfg_div    offered ratio N
//   cfg_ready  pending buffer empty, ratio can be accepted
//   cfg_err    one-cycle pulse after a zero ratio was accepted
//   running    state is RUN or DRAIN
//   count      current counter value
//   tick       high in the last cycle of each running period
//   div_clk    divided clock, flop output
//   state      current FSM state (0 IDLE, 1 RUN, 2 DRAIN) for observation
module clk_div_ctrl #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             running,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             div_clk,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] div_q, div_n;
  logic [WIDTH-1:0] pend_div_q, pend_div_n;
  logic             pend_q, pend_n;
  logic             cfg_err_q, cfg_err_n;
  logic             div_clk_q, div_clk_n;
  logic             accept;
  logic             wrap;
  logic             apply;
  logic [WIDTH:0]   half_n;

  // div_q is never 0, so div_q-1 cannot underflow.
  assign accept = cfg_valid && !pend_q;
  assign wrap   = (state_q != ST_IDLE) && (count_q == div_q - ONE);

  always_comb begin
    state_n    = state_q;
    count_n    = count_q;
    div_n      = div_q;
    pend_n     = pend_q;
    pend_div_n = pend_div_q;
    apply      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_n = '0;
        // While idle there is no period to protect, so a pending ratio is
        // loaded at once. This also covers the IDLE->RUN edge.
        apply   = pend_q;
        if (enable) state_n = ST_RUN;
      end
      ST_RUN: begin
        count_n = wrap ? '0 : count_q + ONE;
        apply   = wrap && pend_q;
        if (!enable) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        count_n = wrap ? '0 : count_q + ONE;
        apply   = wrap && pend_q;
        if (enable)    state_n = ST_RUN;
        else if (wrap) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        count_n = '0;
      end
    endcase

    // apply needs pend_q=1 and accept needs pend_q=0, so at most one fires.
    if (apply) begin
      div_n  = pend_div_q;
      pend_n = 1'b0;
    end
    if (accept && (cfg_div != '0)) begin
      pend_n     = 1'b1;
      pend_div_n = cfg_div;
    end

    cfg_err_n = accept && (cfg_div == '0);

    // Threshold is computed one bit wider so that div_n = 2^WIDTH-1 does
    // not wrap when 1 is added.
    half_n    = ({1'b0, div_n} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    div_clk_n = (state_n != ST_IDLE) && ({1'b0, count_n} < half_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      div_q      <= DEF_DIV;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      cfg_err_q  <= 1'b0;
      div_clk_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      div_q      <= div_n;
      pend_q     <= pend_n;
      pend_div_q <= pend_div_n;
      cfg_err_q  <= cfg_err_n;
      div_clk_q  <= div_clk_n;
    end
  end

  assign cfg_ready = !pend_q;
  assign cfg_err   = cfg_err_q;
  assign running   = (state_q != ST_IDLE);
  assign count     = count_q;
  assign tick      = wrap;
  assign div_clk   = div_clk_q;
  assign state     = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed testbench for clk_div_ctrl (WIDTH=4, DEFAULT_DIV=2).
// Inputs change and outputs are sampled on the falling edge. Each cycle's
// expected {state, running, tick, div_clk, count} is queued in exp_q and
// compared against the DUT.
module tb_clk_div_ctrl;

  localparam int W = 4;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         running;
  logic [W-1:0] count;
  logic         tick;
  logic         div_clk;
  logic [1:0]   state;

  always #5 clk = ~clk;

  clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .running   (running),
    .count     (count),
    .tick      (tick),
    .div_clk   (div_clk),
    .state     (state)
  );

  // scoreboard
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs;

  assign obs = {state, running, tick, div_clk, count};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver / expectation helpers
  task automatic push(input logic [1:0] st, input logic r, input logic t,
                      input logic d, input logic [3:0] c);
    exp_q.push_back({st, r, t, d, c});
  endtask

  // Queue cnt running cycles of a ratio-n period, starting at count 'from'.
  task automatic push_run(input int st, input int n, input int from, input int cnt);
    int c;
    c = from;
    for (int i = 0; i < cnt; i++) begin
      push(2'(st), 1'b1, (c == n - 1), (c < (n + 1) / 2), 4'(c));
      c = (c == n - 1) ? 0 : c + 1;
    end
  endtask

  task automatic run_seq(input string tag, input int n);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        $display("FAIL %s: expectation queue empty", tag);
        $fatal(1, "bench error");
      end
      e = exp_q.pop_front();
      check(tag, 32'(obs), 32'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;

    // Reset and default ratio 2
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_obs",   32'(obs), 32'h0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_err",   32'(cfg_err), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;
    push(1, 1, 0, 1, 0);
    push(1, 1, 1, 0, 1);
    push(1, 1, 0, 1, 0);
    push(1, 1, 1, 0, 1);
    push(1, 1, 0, 1, 0);
    run_seq("t1_run", 5);
    enable = 1'b0;
    push(2, 1, 1, 0, 1);
    push(0, 0, 0, 0, 0);
    run_seq("t1_stop", 2);

    // Ratio 5: program in IDLE, start, drain from count 1
    cfg_valid = 1'b1;
    cfg_div   = 4'd5;
    @(negedge clk);
    check("t2_ready_low", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    @(negedge clk);
    check("t2_ready_back", 32'(cfg_ready), 32'd1);
    check("t2_idle", 32'(obs), 32'h0);
    enable = 1'b1;
    push(1, 1, 0, 1, 0);
    push(1, 1, 0, 1, 1);
    push(1, 1, 0, 1, 2);
    push(1, 1, 0, 0, 3);
    push(1, 1, 1, 0, 4);
    push(1, 1, 0, 1, 0);
    push(1, 1, 0, 1, 1);
    run_seq("t2_run", 7);
    enable = 1'b0;
    push(2, 1, 0, 1, 2);
    push(2, 1, 0, 0, 3);
    push(2, 1, 1, 0, 4);
    push(0, 0, 0, 0, 0);
    run_seq("t2_drain", 4);

    // N=3, then change to 7 mid-period; second offer held off
    cfg_valid = 1'b1;
    cfg_div   = 4'd3;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t3_pend_ready", 32'(cfg_ready), 32'd0);
    enable = 1'b1;
    push_run(1, 3, 0, 4);
    run_seq("t3_n3", 4);
    check("t3_ready_pre", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_div   = 4'd7;
    push_run(1, 3, 1, 1);
    run_seq("t3_n3b", 1);
    check("t3_ready_acc", 32'(cfg_ready), 32'd0);
    cfg_div = 4'd9;
    push_run(1, 3, 2, 1);
    run_seq("t3_wrap", 1);
    check("t3_ready_wrap", 32'(cfg_ready), 32'd0);
    push_run(1, 7, 0, 1);
    run_seq("t3_n7_start", 1);
    check("t3_ready_ret", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    push_run(1, 7, 1, 14);
    run_seq("t3_n7", 14);

    // Illegal ratio 0
    cfg_valid = 1'b1;
    cfg_div   = 4'd0;
    push_run(1, 7, 1, 1);
    run_seq("t4_run", 1);
    check("t4_err_pulse", 32'(cfg_err), 32'd1);
    check("t4_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    push_run(1, 7, 2, 1);
    run_seq("t4_run2", 1);
    check("t4_err_clear", 32'(cfg_err), 32'd0);
    push_run(1, 7, 3, 6);
    run_seq("t4_keep7", 6);

    // Drain re-enable, then N=1
    enable = 1'b0;
    push(2, 1, 0, 1, 2);
    run_seq("t5_drain", 1);
    enable = 1'b1;
    push_run(1, 7, 3, 5);
    run_seq("t5_reen", 5);
    cfg_valid = 1'b1;
    cfg_div   = 4'd1;
    push_run(1, 7, 1, 1);
    run_seq("t5_acc", 1);
    cfg_valid = 1'b0;
    check("t5_ready_low", 32'(cfg_ready), 32'd0);
    push_run(1, 7, 2, 5);
    push_run(1, 1, 0, 4);
    run_seq("t5_n1", 9);
    enable = 1'b0;
    push(2, 1, 1, 1, 0);
    push(0, 0, 0, 0, 0);
    run_seq("t5_n1_stop", 2);

    // Reset at count 3 of N=6 with a ratio pending
    cfg_valid = 1'b1;
    cfg_div   = 4'd6;
    @(negedge clk);
    cfg_valid = 1'b0;
    enable    = 1'b1;
    push_run(1, 6, 0, 2);
    run_seq("t6_n6", 2);
    cfg_valid = 1'b1;
    cfg_div   = 4'd4;
    push_run(1, 6, 2, 1);
    run_seq("t6_n6b", 1);
    cfg_valid = 1'b0;
    check("t6_pend", 32'(cfg_ready), 32'd0);
    push_run(1, 6, 3, 1);
    run_seq("t6_n6c", 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_obs",   32'(obs), 32'h0);
    check("t6_rst_ready", 32'(cfg_ready), 32'd1);
    check("t6_rst_err",   32'(cfg_err), 32'd0);
    rst = 1'b0;
    push(1, 1, 0, 1, 0);
    push(1, 1, 1, 0, 1);
    push(1, 1, 0, 1, 0);
    run_seq("t6_default", 3);
    enable = 1'b0;

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable clock-enable and divided-clock controller for the clock generation and distribution tree. It sequences an internal WIDTH-bit up-counter through start, run and drain phases, and emits a one-cycle `tick` enable plus a registered `div_clk` at the active divide ratio. It accepts new ratios through a valid/ready handshake and applies them only at a period boundary, so downstream counters and flops never see a truncated or runt period.

## Interface
- `WIDTH`, default 4: counter and ratio width.
- `DEFAULT_DIV`, default 2: active ratio after reset. Legal range 1..2^WIDTH-1.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `enable`  in  1: run request (level).
- `cfg_valid`  in  1: new ratio offered.
- `cfg_div`  in  WIDTH: offered ratio N.
- `cfg_ready`  out  1: controller can accept a ratio.
- `cfg_err`  out  1: one-cycle pulse when a ratio of 0 is accepted.
- `running`  out  1: state is RUN or DRAIN.
- `count`  out  WIDTH: internal counter value (registered).
- `tick`  out  1: one-cycle enable at the end of each period.
- `div_clk`  out  1: divided clock (flop output).

## Operation
- **Active ratio register.**
  - `div_q` resets to DEFAULT_DIV.
  - `pend_q` / `pend_div` form a one-entry pending-ratio buffer.
- **Handshake.**
  - `cfg_ready = !pend_q`.
  - Transfer occurs when `cfg_valid && cfg_ready`.
  - `cfg_div == 0`: the transfer completes and the value is discarded. `cfg_err` pulses high for 1 cycle in the following cycle. `pend_q` is not set.
- **IDLE** (reset state).
  - `count = 0`, `tick = 0`, `div_clk = 0`.
  - If `pend_q` is set, load `div_q <= pend_div` and clear `pend_q`.
  - `enable = 1` → RUN on the next cycle, with `count = 0`. A pending ratio is applied in that same transition.
- **RUN.**
  - `count` increments each cycle.
  - When `count == div_q-1`, `count` wraps to 0 (the wrap cycle).
  - If `pend_q` is set in the wrap cycle, `div_q <= pend_div` and `pend_q` clears. The new ratio governs the period starting at `count = 0`.
  - `enable = 0` → DRAIN. Counting continues uninterrupted.
- **DRAIN.**
  - Counting continues as in RUN.
  - `enable = 1` → back to RUN with no break in the count sequence.
  - In the wrap cycle with `enable = 0` → IDLE, with `count = 0`. A pending ratio is applied on entering IDLE.
- **tick** is a decode: `tick = running && (count == div_q-1)`. With N=1, `tick` is high every running cycle.
- **div_clk.**
  - Registered from next-state values.
  - High while running and the next count is < (`div_q`+1)>>1.
  - N=1: constant 1 while running. N=2: 1/0 alternating. N=3: 1,1,0.
  - Low in IDLE.
- **Arithmetic.**
  - Count compare is unsigned, WIDTH bits.
  - `count` never exceeds `div_q-1`.
  - There is no overflow path, because `div_q` ≥ 1 always holds.

## Timing
- **Reset.**
  - `rst` sampled high at an edge gives: state IDLE, `count = 0`, `div_q = DEFAULT_DIV`, `pend_q = 0`, `cfg_err = 0`, `div_clk = 0`, `running = 0`, `cfg_ready = 1`.
  - Reset mid-period aborts immediately. No drain occurs and the pending ratio is lost.
  - `rst` has priority over every other input.
- **Start latency.** `enable` rises at cycle k in IDLE → `running = 1` and `count = 0` at k+1. The first `tick` occurs at cycle k+N.
- **Period.**
  - Ticks are exactly N cycles apart in steady state.
  - After a ratio change from N to M, the gap between ticks is N (the old period completes), then M.
- **Handshake timing.**
  - A ratio accepted in the wrap cycle itself takes effect at the next wrap, not the current one.
  - `cfg_ready` drops in the cycle after acceptance and returns high in the cycle after the ratio is applied.
  - `cfg_valid` held high with `cfg_ready = 0` is not consumed.
- **Stop latency.** `enable` falls during a period → that period completes, `tick` fires once more, and `running = 0` in the following cycle.

## Test plan
- **Reset and default ratio.** Apply `rst = 1` for 2 cycles, then `enable = 1`. Required response: `running` goes high 1 cycle later, `tick` every 2 cycles, `div_clk` alternates 1,0, and `count` follows 0,1,0,1.
- **Ratio 5, start and drain.** Program `cfg_div = 5` in IDLE, then set `enable = 1`. Required response: ticks are 5 cycles apart and `div_clk` follows 1,1,1,0,0. Drop `enable` at `count = 1`: counting continues to 4, `tick` fires, then IDLE with `count = 0`.
- **Change at boundary.** Run at N=3, then offer `cfg_div = 7` mid-period. Required response: the current 3-cycle period completes, then ticks are 7 cycles apart. `cfg_ready` is low from acceptance until the wrap, and a second offer during that window is held unconsumed.
- **Illegal ratio.** Offer `cfg_div = 0`. Required response: it is accepted, `cfg_err` pulses for 1 cycle, and the active ratio is unchanged.
- **Drain re-enable and N=1.** Drop `enable` and re-raise it within DRAIN. Required response: no gap in ticks. Then set N=1: `tick` and `div_clk` are constantly 1 while running.
- **Reset mid-operation.** Assert `rst` at `count = 3` of N=6 while a ratio is pending. Required response: next cycle shows IDLE, `count = 0`, `div_q = 2`, `pend_q = 0`, `tick = 0`.
